// File: rtl/mem_alu_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_alu_sched_if : request/response bundle for the shared address ALU |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mem_alu_sched_if #(
   parameter int N_REQ = 2,
   parameter int ID_W  = 2
) ();
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [2*N_REQ-1:0]  req_op;
   logic [64*N_REQ-1:0] req_a;
   logic [64*N_REQ-1:0] req_b;
   logic                resp_valid;
   logic                resp_ready;
   logic [63:0]         resp_res;
   logic [ID_W-1:0]     resp_id;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_res, resp_id
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_res, resp_id
   );
endinterface
`default_nettype wire

// File: rtl/mem_alu_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_alu_sched : round-robin share of one 64-bit add/sub address ALU   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_alu_sched #(
   parameter int N_REQ = 2,
   parameter int ID_W  = 2
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic        flush,
   mem_alu_sched_if.slave   bus
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [63:0]     res_q, res_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [1:0]      rr_ptr_q, rr_ptr_d;

   logic            can_accept;
   logic            found;
   logic            grant;
   logic [1:0]      win;
   logic [2:0]      cand;
   logic [1:0]      op_sel;
   logic [63:0]     a_sel;
   logic [63:0]     b_sel;
   logic [63:0]     alu_res;
   logic [N_REQ-1:0] ready_w;

   // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      found = 1'b0;
      win   = 2'd0;
      cand  = 3'd0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + 3'(k);
         if (cand >= 3'(N_REQ)) begin
            cand = cand - 3'(N_REQ);
         end
         for (int j = 0; j < N_REQ; j++) begin
            if (!found && (cand == 3'(j)) && bus.req_valid[j]) begin
               found = 1'b1;
               win   = 2'(j);
            end
         end
      end
   end

   always_comb begin
      op_sel = 2'd0;
      a_sel  = 64'd0;
      b_sel  = 64'd0;
      for (int j = 0; j < N_REQ; j++) begin
         if (win == 2'(j)) begin
            op_sel = bus.req_op[2*j +: 2];
            a_sel  = bus.req_a[64*j +: 64];
            b_sel  = bus.req_b[64*j +: 64];
         end
      end
   end

   always_comb begin
      case (op_sel)
         2'b00, 2'b01: alu_res = a_sel + b_sel;
         default:      alu_res = a_sel - b_sel;
      endcase
   end

   // rst_n gates the grant so nothing is offered while reset is held.
   assign can_accept = (state_q == ST_EMPTY) || bus.resp_ready;
   assign grant      = found && can_accept && !flush && rst_n;

   always_comb begin
      ready_w = '0;
      for (int j = 0; j < N_REQ; j++) begin
         ready_w[j] = grant && (win == 2'(j));
      end
   end

   always_comb begin
      state_d  = state_q;
      res_d    = res_q;
      id_d     = id_q;
      rr_ptr_d = rr_ptr_q;
      if (flush) begin
         state_d  = ST_EMPTY;
         rr_ptr_d = 2'd0;
      end else if (grant) begin
         state_d  = ST_FULL;
         res_d    = alu_res;
         id_d     = ID_W'(win);
         rr_ptr_d = (win == 2'(N_REQ-1)) ? 2'd0 : win + 2'd1;
      end else if ((state_q == ST_FULL) && bus.resp_ready) begin
         state_d  = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         res_q    <= 64'd0;
         id_q     <= '0;
         rr_ptr_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         res_q    <= res_d;
         id_q     <= id_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign bus.req_ready  = ready_w;
   assign bus.resp_valid = (state_q == ST_FULL);
   assign bus.resp_res   = res_q;
   assign bus.resp_id    = id_q;

endmodule
`default_nettype wire
